// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first. Pins are synchronized into clk_in; a one-deep
// TX buffer feeds each frame and single-cycle pulses report frame events.
module spi_target #(
  parameter int SIZE        = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            sclk_in,
  input  logic            cs_n_in,
  input  logic            mosi_in,
  output logic            miso_out,
  input  logic [SIZE-1:0] tx_data_in,
  input  logic            tx_load_in,
  output logic [SIZE-1:0] rx_data_out,
  output logic            rx_valid_out,
  output logic            tx_underrun_out,
  output logic            frame_error_out,
  output logic            busy_out,
  output logic [1:0]      state_dbg
);
  localparam int CW = $clog2(SIZE) + 1;
  localparam int FW = $clog2(SYNC_STAGES + 1) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CW-1:0] BITS_FULL  = CW'(SIZE);
  localparam logic [FW-1:0] FLUSH_DONE = FW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic [FW-1:0]          flush_cnt;
  logic                   armed;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Synchronizer chains. After reset the chain still holds idle levels, so a
  // frame start is accepted only once a real (flushed) high cs_n has been seen.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      if (flush_cnt != FLUSH_DONE) flush_cnt <= flush_cnt + 1'b1;
      if ((flush_cnt == FLUSH_DONE) && cs_s) armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = armed & cs_prev & ~cs_s;
  assign cs_rise   = cs_s & ~cs_prev;

  logic [1:0]      state;
  logic [CW-1:0]   bit_cnt;
  logic [SIZE-1:0] rx_shift;
  logic [SIZE-1:0] tx_shift;
  logic [SIZE-1:0] tx_buf;
  logic            tx_pending;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state           <= ST_IDLE;
      bit_cnt         <= '0;
      rx_shift        <= '0;
      tx_shift        <= '0;
      tx_buf          <= '0;
      tx_pending      <= 1'b0;
      rx_data_out     <= '0;
      rx_valid_out    <= 1'b0;
      tx_underrun_out <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      rx_valid_out    <= 1'b0;
      tx_underrun_out <= 1'b0;
      frame_error_out <= 1'b0;
      if (tx_load_in) begin
        tx_buf     <= tx_data_in;
        tx_pending <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state      <= ST_SHIFT;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_pending <= 1'b0;
            // A load arriving with the frame start goes straight into this frame.
            if (tx_load_in) begin
              tx_shift <= tx_data_in;
            end else if (tx_pending) begin
              tx_shift <= tx_buf;
            end else begin
              tx_shift        <= '0;
              tx_underrun_out <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          // cs_n edges win over any sclk edge seen in the same cycle.
          if (cs_rise) begin
            state <= ST_IDLE;
            if (bit_cnt == BITS_FULL) begin
              rx_data_out  <= rx_shift;
              rx_valid_out <= 1'b1;
            end else if (bit_cnt != '0) begin
              frame_error_out <= 1'b1;
            end
          end else if (bit_cnt == BITS_FULL) begin
            rx_data_out  <= rx_shift;
            rx_valid_out <= 1'b1;
            state        <= ST_DONE;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[SIZE-2:0], mosi_s};
            bit_cnt  <= bit_cnt + 1'b1;
          end else if (sclk_fall) begin
            tx_shift <= {tx_shift[SIZE-2:0], 1'b0};
          end
        end
        ST_DONE: begin
          if (cs_rise) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign miso_out  = (state == ST_SHIFT) & tx_shift[SIZE-1];
  assign busy_out  = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: directed frames plus random frames, every cycle checked
// against a pin-level behavioural model of the SPI target.
module tb_spi_target;
  localparam int SIZE = 8;
  localparam int S    = 2;

  logic            clk = 1'b0;
  logic            reset_in = 1'b1;
  logic            sclk = 1'b0;
  logic            cs_n = 1'b1;
  logic            mosi = 1'b0;
  logic            miso_out;
  logic [SIZE-1:0] tx_data = '0;
  logic            tx_load = 1'b0;
  logic [SIZE-1:0] rx_data_out;
  logic            rx_valid_out;
  logic            tx_underrun_out;
  logic            frame_error_out;
  logic            busy_out;
  logic [1:0]      state_dbg;

  spi_target #(.SIZE(SIZE), .SYNC_STAGES(S)) dut (
    .clk_in(clk), .reset_in(reset_in), .sclk_in(sclk), .cs_n_in(cs_n),
    .mosi_in(mosi), .miso_out(miso_out), .tx_data_in(tx_data),
    .tx_load_in(tx_load), .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out),
    .tx_underrun_out(tx_underrun_out), .frame_error_out(frame_error_out),
    .busy_out(busy_out), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pins reach the design logic S+1 cycles late; the model keeps the last S+1
  // samples and reacts to edges seen at the end of that delay line.
  logic            h_sclk [0:S];
  logic            h_cs   [0:S];
  logic            h_mosi [0:S];
  bit              h_real [0:S];
  bit              m_armed, m_in_frame, m_complete, m_pending;
  int              m_bits, m_falls;
  logic [SIZE-1:0] m_rx_acc, m_tx_word, m_tx_buf, m_rx_data;
  logic            e_rx_valid, e_underrun, e_ferr, e_miso;

  always @(posedge clk) begin
    logic c_s, p_s, c_c, p_c, c_m;
    bit   s_rise, s_fall, c_fall, c_rise, was_in, start;
    if (reset_in) begin
      for (int k = 0; k <= S; k++) begin
        h_sclk[k] = 1'b0; h_cs[k] = 1'b1; h_mosi[k] = 1'b0; h_real[k] = 1'b0;
      end
      m_armed = 0; m_in_frame = 0; m_complete = 0; m_pending = 0;
      m_bits = 0; m_falls = 0;
      m_rx_acc = '0; m_tx_word = '0; m_tx_buf = '0; m_rx_data = '0;
      e_rx_valid = 0; e_underrun = 0; e_ferr = 0;
    end else begin
      c_s = h_sclk[S-1]; p_s = h_sclk[S];
      c_c = h_cs[S-1];   p_c = h_cs[S];
      c_m = h_mosi[S-1];
      s_rise = c_s && !p_s;
      s_fall = !c_s && p_s;
      c_fall = m_armed && p_c && !c_c;
      c_rise = c_c && !p_c;
      if (h_real[S-1] && c_c) m_armed = 1;
      e_rx_valid = 0; e_underrun = 0; e_ferr = 0;
      was_in = m_in_frame;
      start  = !was_in && c_fall;
      if (start) begin
        m_in_frame = 1; m_complete = 0; m_bits = 0; m_falls = 0; m_rx_acc = '0;
        if (tx_load)        m_tx_word = tx_data;
        else if (m_pending) m_tx_word = m_tx_buf;
        else begin m_tx_word = '0; e_underrun = 1; end
      end
      if (tx_load) begin m_tx_buf = tx_data; m_pending = 1; end
      if (start) m_pending = 0;
      if (was_in) begin
        if (c_rise) begin
          if (!m_complete && m_bits == SIZE) begin m_rx_data = m_rx_acc; e_rx_valid = 1; end
          else if (!m_complete && m_bits > 0) e_ferr = 1;
          m_in_frame = 0;
        end else if (!m_complete) begin
          if (m_bits == SIZE) begin
            m_rx_data = m_rx_acc; e_rx_valid = 1; m_complete = 1;
          end else if (s_rise) begin
            m_rx_acc = SIZE'(m_rx_acc * 2 + c_m);
            m_bits++;
          end else if (s_fall) begin
            m_falls++;
          end
        end
      end
      for (int k = S; k > 0; k--) begin
        h_sclk[k] = h_sclk[k-1]; h_cs[k] = h_cs[k-1];
        h_mosi[k] = h_mosi[k-1]; h_real[k] = h_real[k-1];
      end
      h_sclk[0] = sclk; h_cs[0] = cs_n; h_mosi[0] = mosi; h_real[0] = 1;
    end
    e_miso = (m_in_frame && !m_complete && m_falls < SIZE) ? m_tx_word[SIZE-1-m_falls] : 1'b0;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("miso", 32'(miso_out), 32'(e_miso));
      check("busy", 32'(busy_out), 32'(m_in_frame));
      check("rx_valid", 32'(rx_valid_out), 32'(e_rx_valid));
      check("tx_underrun", 32'(tx_underrun_out), 32'(e_underrun));
      check("frame_error", 32'(frame_error_out), 32'(e_ferr));
      check("rx_data", 32'(rx_data_out), 32'(m_rx_data));
    end
  end

  // ---------------- pulse counters for directed checks ----------------
  int cnt_valid = 0, cnt_under = 0, cnt_ferr = 0;
  always @(negedge clk) begin
    if (rx_valid_out)    cnt_valid++;
    if (tx_underrun_out) cnt_under++;
    if (frame_error_out) cnt_ferr++;
  end

  task automatic clear_counts();
    cnt_valid = 0; cnt_under = 0; cnt_ferr = 0;
  endtask

  // ---------------- driver tasks ----------------
  int              opt_load_at  = -1;
  int              opt_reset_at = -1;
  bit              opt_coincide = 1'b0;
  logic [SIZE-1:0] opt_load_val = '0;

  task automatic pulse_load(input logic [SIZE-1:0] val);
    tx_data = val;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic spi_frame(input logic [SIZE-1:0] data, input int nbits, input int half,
                           output logic [SIZE-1:0] miso_bits);
    miso_bits = '0;
    cs_n = 1'b0;
    mosi = data[SIZE-1];
    for (int j = 1; j <= half; j++) begin
      @(negedge clk);
      tx_load = opt_coincide && (j == S);
      if (opt_coincide && (j == S)) tx_data = opt_load_val;
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == opt_load_at) pulse_load(opt_load_val);
      if (i == opt_reset_at) begin
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
      end
      if (i < SIZE) miso_bits[SIZE-1-i] = miso_out;
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
      mosi = (i + 1 < SIZE) ? data[SIZE-2-i] : 1'b1;
      repeat (half) @(negedge clk);
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (half + 2) @(negedge clk);
    opt_load_at = -1; opt_reset_at = -1; opt_coincide = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [SIZE-1:0] mb;
    logic [SIZE-1:0] rv;
    int half, nb;
    @(negedge clk);
    reset_in = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_rx_data", 32'(rx_data_out), 32'h0);
    check("reset_busy", 32'(busy_out), 32'h0);
    check("reset_miso", 32'(miso_out), 32'h0);
    check("reset_pulses", 32'({rx_valid_out, tx_underrun_out, frame_error_out}), 32'h0);
    reset_in = 1'b0;
    repeat (10) @(negedge clk);

    // Loaded frame: receive 0x3C while sending 0xA5.
    clear_counts();
    pulse_load(8'hA5);
    spi_frame(8'h3C, 8, 8, mb);
    check("f1_rx_data", 32'(rx_data_out), 32'h3C);
    check("f1_valid_cnt", 32'(cnt_valid), 32'd1);
    check("f1_miso", 32'(mb), 32'hA5);
    check("f1_under_cnt", 32'(cnt_under), 32'd0);

    // No load: underrun once, miso all zero.
    clear_counts();
    spi_frame(8'h5A, 8, 8, mb);
    check("f2_under_cnt", 32'(cnt_under), 32'd1);
    check("f2_miso", 32'(mb), 32'h00);
    check("f2_rx_data", 32'(rx_data_out), 32'h5A);

    // Aborted after 5 bits.
    clear_counts();
    spi_frame(8'hFF, 5, 8, mb);
    check("f3_ferr_cnt", 32'(cnt_ferr), 32'd1);
    check("f3_rx_kept", 32'(rx_data_out), 32'h5A);
    check("f3_busy", 32'(busy_out), 32'h0);
    check("f3_valid_cnt", 32'(cnt_valid), 32'd0);

    // Ten clocks in one frame: only the first eight count.
    clear_counts();
    spi_frame(8'h96, 10, 8, mb);
    check("f4_rx_data", 32'(rx_data_out), 32'h96);
    check("f4_valid_cnt", 32'(cnt_valid), 32'd1);
    check("f4_ferr_cnt", 32'(cnt_ferr), 32'd0);

    // Reset at bit 4, then a clean 0x81 frame.
    clear_counts();
    opt_reset_at = 4;
    spi_frame(8'hC3, 8, 8, mb);
    check("f5_valid_cnt", 32'(cnt_valid), 32'd0);
    check("f5_ferr_cnt", 32'(cnt_ferr), 32'd0);
    check("f5_rx_cleared", 32'(rx_data_out), 32'h00);
    clear_counts();
    spi_frame(8'h81, 8, 8, mb);
    check("f6_rx_data", 32'(rx_data_out), 32'h81);
    check("f6_valid_cnt", 32'(cnt_valid), 32'd1);

    // Load mid-frame affects only the following frame.
    pulse_load(8'h33);
    opt_load_at = 3; opt_load_val = 8'h55;
    spi_frame(8'hF0, 8, 8, mb);
    check("f7_miso_current", 32'(mb), 32'h33);
    check("f7_rx_data", 32'(rx_data_out), 32'hF0);
    clear_counts();
    spi_frame(8'h0F, 8, 8, mb);
    check("f8_miso_next", 32'(mb), 32'h55);
    check("f8_under_cnt", 32'(cnt_under), 32'd0);

    // Load landing in the same cycle as the frame start.
    clear_counts();
    opt_coincide = 1'b1; opt_load_val = 8'h6E;
    spi_frame(8'h11, 8, 6, mb);
    check("f9_miso_coincide", 32'(mb), 32'h6E);
    check("f9_under_cnt", 32'(cnt_under), 32'd0);
    clear_counts();
    spi_frame(8'h22, 8, 6, mb);
    check("f10_under_cnt", 32'(cnt_under), 32'd1);

    // Random frames: lengths, phases, loads and data.
    for (int n = 0; n < 40; n++) begin
      half = $urandom_range(4, 10);
      if ($urandom_range(0, 1) == 1) begin
        rv = SIZE'($urandom);
        pulse_load(rv);
      end
      nb = ($urandom_range(0, 9) < 6) ? SIZE : $urandom_range(0, SIZE + 3);
      if ($urandom_range(0, 3) == 0) begin
        opt_load_at  = $urandom_range(0, SIZE - 1);
        opt_load_val = SIZE'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        opt_coincide = 1'b1;
        opt_load_val = SIZE'($urandom);
      end
      rv = SIZE'($urandom);
      spi_frame(rv, nb, half, mb);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
